// File: rtl/dense_sequencer.sv
// Dense layer sequencer: streams features from the feature RAM into the Dense
// unit, captures the Dense results into a register bank and tracks the signed
// argmax so the predicted class is ready when done pulses.
module dense_sequencer #(
  parameter int IN_COUNT  = 10,
  parameter int OUT_COUNT = 3,
  parameter int DATA_SIZE = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         go,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(IN_COUNT)-1:0]  featAdr,
  output logic                         featRd,
  input  logic [DATA_SIZE-1:0]         featData,
  output logic                         denseStart,
  output logic [DATA_SIZE-1:0]         denseDataIn,
  input  logic                         denseBusy,
  input  logic                         denseValid,
  input  logic [DATA_SIZE-1:0]         denseDataOut,
  input  logic [$clog2(OUT_COUNT)-1:0] resultIdx,
  output logic [DATA_SIZE-1:0]         resultData,
  output logic [$clog2(OUT_COUNT)-1:0] classOut
);

  localparam int ADR_W  = $clog2(IN_COUNT);
  localparam int CLS_W  = $clog2(OUT_COUNT);
  localparam int OCNT_W = $clog2(OUT_COUNT + 1);

  typedef enum logic [2:0] {IDLE, PRIME, START, FEED, COLLECT, DONE} state_t;

  state_t                      state;
  logic [ADR_W-1:0]            feed_cnt;
  logic [OCNT_W-1:0]           out_cnt;
  logic signed [DATA_SIZE-1:0] result_q [OUT_COUNT];
  logic signed [DATA_SIZE-1:0] best_val;
  logic [CLS_W-1:0]            best_idx;

  logic signed [DATA_SIZE-1:0] cand_val;
  logic                        capture;
  logic                        last_capture;
  logic                        cand_wins;
  logic [CLS_W-1:0]            new_idx;

  // Strict signed greater-than: on a tie the earlier (lower) index is kept.
  function automatic logic beats(input logic signed [DATA_SIZE-1:0] cand,
                                 input logic signed [DATA_SIZE-1:0] best);
    return cand > best;
  endfunction

  assign cand_val     = $signed(denseDataOut);
  assign capture      = (state == COLLECT) && denseValid && (int'(out_cnt) < OUT_COUNT);
  assign last_capture = capture && (int'(out_cnt) == OUT_COUNT - 1);
  assign cand_wins    = (out_cnt == '0) || beats(cand_val, best_val);
  assign new_idx      = cand_wins ? CLS_W'(out_cnt) : best_idx;

  // Feature words pass straight through to Dense only while feeding.
  assign denseDataIn = (state == FEED) ? featData : '0;

  // Result readout; out-of-range selects read as zero.
  always_comb begin
    resultData = '0;
    for (int i = 0; i < OUT_COUNT; i++) begin
      if (int'(resultIdx) == i) resultData = result_q[i];
    end
  end

  // Sequencer FSM. RAM address/read-enable are registered one state ahead so
  // that, with the RAM's one-cycle latency, word k lands in FEED cycle k.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      featRd     <= 1'b0;
      featAdr    <= '0;
      denseStart <= 1'b0;
      classOut   <= '0;
      feed_cnt   <= '0;
      out_cnt    <= '0;
      best_val   <= '0;
      best_idx   <= '0;
      for (int i = 0; i < OUT_COUNT; i++) result_q[i] <= '0;
    end else begin
      done       <= 1'b0;
      denseStart <= 1'b0;
      case (state)
        IDLE: begin
          if (go && !denseBusy) begin
            busy  <= 1'b1;
            state <= PRIME;
          end
        end
        PRIME: begin
          featRd     <= 1'b1;
          featAdr    <= '0;
          denseStart <= 1'b1;
          state      <= START;
        end
        START: begin
          featAdr  <= ADR_W'(1);
          feed_cnt <= '0;
          state    <= FEED;
        end
        FEED: begin
          if (int'(feed_cnt) + 2 < IN_COUNT) featAdr <= feed_cnt + ADR_W'(2);
          if (int'(feed_cnt) == IN_COUNT - 1) begin
            featRd  <= 1'b0;
            out_cnt <= '0;
            state   <= COLLECT;
          end else begin
            feed_cnt <= feed_cnt + ADR_W'(1);
          end
        end
        COLLECT: begin
          if (capture) begin
            for (int i = 0; i < OUT_COUNT; i++) begin
              if (int'(out_cnt) == i) result_q[i] <= cand_val;
            end
            out_cnt  <= out_cnt + OCNT_W'(1);
            best_idx <= new_idx;
            if (cand_wins) best_val <= cand_val;
            if (last_capture) begin
              classOut <= new_idx;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_sequencer.sv
// Directed bench for dense_sequencer: feature RAM model, scripted Dense
// responses, a vector table of inference runs and a few hand-built sequences.
module tb_dense_sequencer;
  localparam int IN  = 10;
  localparam int OUT = 3;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         go = 1'b0;
  logic         busy, done, featRd, denseStart;
  logic         denseBusy = 1'b0;
  logic         denseValid = 1'b0;
  logic [3:0]   featAdr;
  logic [W-1:0] featData = '0;
  logic [W-1:0] denseDataIn, resultData;
  logic [W-1:0] denseDataOut = '0;
  logic [1:0]   resultIdx = '0;
  logic [1:0]   classOut;

  logic [W-1:0] ram [IN];

  int checks = 0;
  int errors = 0;
  int starts, dones, feed_ok, max_adr, lat;

  typedef struct {
    logic [15:0] r0, r1, r2;
    int          gap;
    int          go_feed;
    int          go_done;
    logic [1:0]  cls;
  } vec_t;
  vec_t vecs [6];

  dense_sequencer #(.IN_COUNT(IN), .OUT_COUNT(OUT), .DATA_SIZE(W)) dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
    .featAdr(featAdr), .featRd(featRd), .featData(featData),
    .denseStart(denseStart), .denseDataIn(denseDataIn),
    .denseBusy(denseBusy), .denseValid(denseValid), .denseDataOut(denseDataOut),
    .resultIdx(resultIdx), .resultData(resultData), .classOut(classOut)
  );

  always #5 clk = ~clk;

  // Feature RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (featRd) featData <= (int'(featAdr) < IN) ? ram[featAdr] : '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One inference: go pulse, RAM-fed stream checked against 1..IN, a stray
  // valid mid-feed, then three Dense results after 'gap' idle collect cycles.
  task automatic run(input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2,
                     input int gap, input int go_feed, input int go_done, input int abort_at);
    logic [15:0] rv [3];
    int fidx, ccyc, vcnt, stop;
    rv[0] = r0; rv[1] = r1; rv[2] = r2;
    starts = 0; dones = 0; feed_ok = 1; max_adr = 0; lat = -1;
    fidx = 0; ccyc = 0; vcnt = 0; stop = 200;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    for (int cyc = 1; cyc < stop; cyc++) begin
      if (int'(featAdr) > max_adr) max_adr = int'(featAdr);
      if (fidx >= 1 && fidx <= IN) begin
        if (denseDataIn !== W'(fidx)) feed_ok = 0;
        if (fidx == 5) begin
          denseValid = 1'b1; denseDataOut = 16'h7FFF;
        end else begin
          denseValid = 1'b0;
        end
        if (fidx == go_feed) go = 1'b1;
        if (fidx == abort_at) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0; denseValid = 1'b0; denseBusy = 1'b0;
          check("abort_busy", busy, 0);
          check("abort_start", denseStart, 0);
          check("abort_featrd", featRd, 0);
          check("abort_class", classOut, 0);
          resultIdx = 2'd0; #1;
          check("abort_result0", resultData, 0);
          return;
        end
        fidx++;
      end else if (fidx > IN) begin
        if (ccyc >= gap && vcnt < 3) begin
          denseValid = 1'b1; denseDataOut = rv[vcnt]; vcnt++;
        end else begin
          denseValid = 1'b0;
          if (vcnt == 3) denseBusy = 1'b0;
        end
        ccyc++;
      end
      if (denseStart) begin
        starts++;
        if (fidx == 0) fidx = 1;
        denseBusy = 1'b1;
      end
      if (done) begin
        dones++;
        if (lat < 0) begin
          lat = cyc; stop = cyc + 5;
          if (go_done != 0) go = 1'b1;
        end
      end
      @(posedge clk); #1;
      go = 1'b0;
    end
    denseValid = 1'b0; denseBusy = 1'b0;
  endtask

  task automatic check_results(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                               input logic [15:0] e2, input logic [1:0] cls);
    logic [15:0] ev [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = 16'h0000;
    check({tag, "_class"}, classOut, cls);
    for (int k = 0; k < 4; k++) begin
      resultIdx = 2'(k); #1;
      check($sformatf("%s_result%0d", tag, k), resultData, ev[k]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_bad;
    for (int i = 0; i < IN; i++) ram[i] = W'(i + 1);
    vecs[0] = '{16'h0005, 16'hFFFE, 16'h0007, 0, 3, 0, 2'd2};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h8000, 0, 0, 1, 2'd0};
    vecs[2] = '{16'h8000, 16'h7FFF, 16'h7FFF, 1, 0, 0, 2'd1};
    vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 2'd0};
    vecs[4] = '{16'h0003, 16'h0009, 16'h0002, 2, 0, 0, 2'd1};
    vecs[5] = '{16'hFFF0, 16'hFFF8, 16'hFFF4, 0, 0, 0, 2'd1};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_start", denseStart, 0);
    check("rst_featrd", featRd, 0);
    check("rst_featadr", featAdr, 0);
    check("rst_datain", denseDataIn, 0);
    check_results("rst", 16'h0, 16'h0, 16'h0, 2'd0);

    // Vector table of full inferences
    for (int i = 0; i < 6; i++) begin
      run(vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].gap, vecs[i].go_feed, vecs[i].go_done, 0);
      check($sformatf("v%0d_starts", i), starts, 1);
      check($sformatf("v%0d_dones", i), dones, 1);
      check($sformatf("v%0d_feed", i), feed_ok, 1);
      check($sformatf("v%0d_adrmax", i), max_adr <= IN - 1, 1);
      check($sformatf("v%0d_latency", i), lat, 16 + vecs[i].gap);
      check($sformatf("v%0d_busy_end", i), busy, 0);
      check_results($sformatf("v%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].cls);
    end

    // go while Dense reports busy in IDLE must be ignored
    denseBusy = 1'b1; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0; idle_bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy || denseStart || done) idle_bad = 1;
      @(posedge clk); #1;
    end
    denseBusy = 1'b0;
    check("idle_busy_go", idle_bad, 0);
    check("idle_busy_class", classOut, 2'd1);

    // Abort in the fourth FEED cycle, then a clean run
    run(16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 4);
    repeat (2) @(posedge clk); #1;
    run(16'h0002, 16'h0010, 16'h000F, 0, 0, 0, 0);
    check("post_abort_starts", starts, 1);
    check("post_abort_dones", dones, 1);
    check("post_abort_feed", feed_ok, 1);
    check("post_abort_latency", lat, 16);
    check_results("post_abort", 16'h0002, 16'h0010, 16'h000F, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
